// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART TX arbiter.
// Latency: none (wires only).
// Backpressure: req is held with data stable until ack; tx_busy holds off new starts.
//
// Ports carried:
//   req       requester -> arbiter   per-requester byte pending
//   req_data  requester -> arbiter   packed bytes, requester i on [8i+7:8i]
//   gnt       arbiter -> requester   one-hot grant, zero when idle
//   ack       arbiter -> requester   one-cycle byte-taken pulse
//   tx_data   arbiter -> uart        byte to transmit
//   tx_start  arbiter -> uart        one-cycle start pulse
//   tx_busy   uart -> arbiter        transmitter busy
//   tx_err    arbiter -> system      busy never rose after a start
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_err;

  // arbiter side
  modport master (
    input  req, req_data, tx_busy,
    output gnt, ack, tx_data, tx_start, tx_err
  );

  // requesters + transmitter side
  modport slave (
    output req, req_data, tx_busy,
    input  gnt, ack, tx_data, tx_start, tx_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ requesters.
// Latency: grant and tx_start/ack one clock after req is sampled in IDLE.
// Backpressure: no new start while tx_busy is high; requesters hold req until ack.
//
// Ports: clk, rst (async active-low), bus (uart_tx_arbiter_if.master):
//   req/req_data in, gnt/ack out, tx_data/tx_start out, tx_busy in, tx_err out.
// Optional feature macro: UART_SRC_TAG_EN -- when defined, each new grant first
// sends a tag byte {4'hA, 1'b0, id[2:0]} (no ack) before the requester's data.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 1,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
  logic [IW-1:0]        ptr_q,   ptr_d;    // last requester served
  logic [IW-1:0]        win_q,   win_d;    // requester currently holding the grant
  logic [3:0]           burst_q, burst_d;  // bytes sent in this grant
  logic [TW-1:0]        to_q,    to_d;     // cycles spent waiting for busy to rise
  logic [7:0]           data_q,  data_d;
  logic                 tag_q,   tag_d;    // byte in flight is a source tag

  logic [IW-1:0]        pick;
  logic                 pick_vld;
  logic                 timeout;

  // Index of the requester k places after base, wrapping modulo NUM_REQ.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return IW'(s);
  endfunction

  function automatic logic [7:0] byte_of(input logic [NUM_REQ*8-1:0] d,
                                         input logic [IW-1:0]        i);
    return d[int'(i)*8 +: 8];
  endfunction

  // Round-robin search: start just after the last winner so that the
  // requester served most recently has the lowest priority.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_vld && bus.req[wrap_idx(ptr_q, k)]) begin
        pick     = wrap_idx(ptr_q, k);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    burst_d = burst_q;
    to_d    = to_q;
    data_d  = data_q;
    tag_d   = tag_q;
    timeout = 1'b0;

    case (state_q)
      IDLE: begin
        // A busy transmitter may belong to a transfer started before reset
        // or by someone else; never start on top of it.
        if (pick_vld && !bus.tx_busy) begin
          gnt_d   = NUM_REQ'(1) << pick;
          win_d   = pick;
          burst_d = 4'd1;
          state_d = START;
`ifdef UART_SRC_TAG_EN
          data_d  = {4'hA, 1'b0, 3'(pick)};
          tag_d   = 1'b1;
`else
          data_d  = byte_of(bus.req_data, pick);
          tag_d   = 1'b0;
`endif
        end
      end

      START: begin
        to_d    = '0;
        state_d = WAIT_HI;
      end

      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (to_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never answered: give up on this grant entirely,
          // including any data byte still queued behind a tag.
          timeout = 1'b1;
          gnt_d   = '0;
          ptr_d   = win_q;
          tag_d   = 1'b0;
          state_d = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end

      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (tag_q) begin
            // Tag is out; the requester's first data byte follows under the
            // same grant. It is still pending since it has not been acked.
            data_d  = byte_of(bus.req_data, win_q);
            tag_d   = 1'b0;
            state_d = START;
          end else if (bus.req[win_q] && (burst_q < 4'(MAX_BURST))) begin
            data_d  = byte_of(bus.req_data, win_q);
            burst_d = burst_q + 4'd1;
            state_d = START;
          end else begin
            gnt_d   = '0;
            ptr_d   = win_q;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      win_q   <= '0;
      burst_q <= '0;
      to_q    <= '0;
      data_q  <= 8'h00;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      burst_q <= burst_d;
      to_q    <= to_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  // START lasts exactly one cycle, so decoding it gives a clean pulse that
  // also clears the instant reset is asserted.
  assign bus.gnt      = gnt_q;
  assign bus.tx_start = (state_q == START);
  assign bus.ack      = ((state_q == START) && !tag_q) ? gnt_q : '0;
  assign bus.tx_data  = data_q;
  assign bus.tx_err   = timeout;

endmodule
